// File: rtl/hash_lut_arbiter.sv
// -----------------------------------------------------------------------------
// hash_lut_arbiter
//
// Purpose:
//   Shares the write port of the hash lookup table between a host (CSR/AMM
//   slave) and an internal clean sweep. The sweep writes CLEAN_DATA to every
//   LUT address, one address per cycle. While the sweep runs, host writes are
//   stalled and the search engines are disabled.
//
// Optional feature:
//   `define HASH_LUT_ARBITER_STAT_EN enables a 16-bit saturating counter of
//   host stall cycles on stall_cnt_o. Without it, stall_cnt_o is tied to 0.
//
// Ports:
//   clk_i                   main clock
//   srst_i                  synchronous active-high reset
//   en_i                    search enable from CSR
//   run_stb_i               single-cycle clean sweep request
//   busy_o                  clean sweep in progress
//   done_o                  single-cycle pulse when a sweep completes
//   search_en_o             gated search enable to the search engines
//   amm_slave_address_i     host write address
//   amm_slave_write_i       host write request
//   amm_slave_writedata_i   host write data
//   amm_slave_waitrequest_o host write stall
//   amm_master_address_o    LUT write address
//   amm_master_write_o      LUT write strobe
//   amm_master_writedata_o  LUT write data
//   stall_cnt_o             count of host stall cycles
// -----------------------------------------------------------------------------
module hash_lut_arbiter #(
    parameter int                         AMM_LUT_ADDR_W = 10,
    parameter int                         AMM_LUT_DATA_W = 8,
    parameter logic [AMM_LUT_DATA_W-1:0]  CLEAN_DATA     = {AMM_LUT_DATA_W{1'b1}}
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      en_i,
    input  logic                      run_stb_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      search_en_o,
    input  logic [AMM_LUT_ADDR_W-1:0] amm_slave_address_i,
    input  logic                      amm_slave_write_i,
    input  logic [AMM_LUT_DATA_W-1:0] amm_slave_writedata_i,
    output logic                      amm_slave_waitrequest_o,
    output logic [AMM_LUT_ADDR_W-1:0] amm_master_address_o,
    output logic                      amm_master_write_o,
    output logic [AMM_LUT_DATA_W-1:0] amm_master_writedata_o,
    output logic [15:0]               stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                      r_state;
    // One extra bit so the counter reaches 2^AMM_LUT_ADDR_W after the last
    // address instead of wrapping to 0; the MSB marks sweep completion.
    logic [AMM_LUT_ADDR_W:0]     r_sweep_cnt;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_search_en;
    logic                        r_mwrite;
    logic [AMM_LUT_ADDR_W-1:0]   r_maddr;
    logic [AMM_LUT_DATA_W-1:0]   r_mdata;

    logic                        w_idle;
    logic                        w_sweep_last;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_sweep_last = r_sweep_cnt[AMM_LUT_ADDR_W];

    // Host is stalled whenever the sweep owns the LUT port.
    assign amm_slave_waitrequest_o = ~w_idle;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state     <= ST_IDLE;
            r_sweep_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_search_en <= 1'b0;
            r_mwrite    <= 1'b0;
            r_maddr     <= '0;
            r_mdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (amm_slave_write_i) begin
                        r_mwrite <= 1'b1;
                        r_maddr  <= amm_slave_address_i;
                        r_mdata  <= amm_slave_writedata_i;
                    end else begin
                        r_mwrite <= 1'b0;
                    end
                    if (run_stb_i) begin
                        r_state     <= ST_CLEAN;
                        r_busy      <= 1'b1;
                        r_search_en <= 1'b0;
                        if (amm_slave_write_i) begin
                            // Host write takes this slot; sweep begins at
                            // address 0 one cycle later.
                            r_sweep_cnt <= '0;
                        end else begin
                            // Issue address 0 immediately so the sweep has
                            // no bubble after the request.
                            r_mwrite    <= 1'b1;
                            r_maddr     <= '0;
                            r_mdata     <= CLEAN_DATA;
                            r_sweep_cnt <= {{AMM_LUT_ADDR_W{1'b0}}, 1'b1};
                        end
                    end else begin
                        r_busy      <= 1'b0;
                        r_search_en <= en_i;
                    end
                end

                ST_CLEAN: begin
                    r_search_en <= 1'b0;
                    if (w_sweep_last) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_mwrite <= 1'b0;
                    end else begin
                        r_busy      <= 1'b1;
                        r_mwrite    <= 1'b1;
                        r_maddr     <= r_sweep_cnt[AMM_LUT_ADDR_W-1:0];
                        r_mdata     <= CLEAN_DATA;
                        r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_mwrite    <= 1'b0;
                    r_sweep_cnt <= '0;
                    r_search_en <= en_i;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_mwrite    <= 1'b0;
                    r_sweep_cnt <= '0;
                    r_search_en <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o                 = r_busy;
    assign done_o                 = r_done;
    assign search_en_o            = r_search_en;
    assign amm_master_write_o     = r_mwrite;
    assign amm_master_address_o   = r_maddr;
    assign amm_master_writedata_o = r_mdata;

`ifdef HASH_LUT_ARBITER_STAT_EN
    // -------------------------------------------------------------------------
    // Host stall statistics
    // -------------------------------------------------------------------------
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_stall_cnt <= '0;
        end else if (w_idle && run_stb_i) begin
            r_stall_cnt <= '0;
        end else if (amm_slave_write_i && amm_slave_waitrequest_o &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_hash_lut_arbiter.sv
module tb_hash_lut_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int NADDR = 1 << AW;
    localparam int MAXC  = 2048;

    logic          clk = 1'b0;
    logic          srst_i;
    logic          en_i;
    logic          run_stb_i;
    logic          busy_o;
    logic          done_o;
    logic          search_en_o;
    logic [AW-1:0] s_addr;
    logic          s_write;
    logic [DW-1:0] s_data;
    logic          s_wait;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_data;
    logic [15:0]   stall_cnt_o;

    always #5 clk = ~clk;

    hash_lut_arbiter #(
        .AMM_LUT_ADDR_W (AW),
        .AMM_LUT_DATA_W (DW)
    ) dut (
        .clk_i                   (clk),
        .srst_i                  (srst_i),
        .en_i                    (en_i),
        .run_stb_i               (run_stb_i),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .search_en_o             (search_en_o),
        .amm_slave_address_i     (s_addr),
        .amm_slave_write_i       (s_write),
        .amm_slave_writedata_i   (s_data),
        .amm_slave_waitrequest_o (s_wait),
        .amm_master_address_o    (m_addr),
        .amm_master_write_o      (m_write),
        .amm_master_writedata_o  (m_data),
        .stall_cnt_o             (stall_cnt_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs per cycle, filled in ahead of time from the rules:
    // host write accepted when the port is free appears one cycle later;
    // an accepted sweep request owns the port until its done cycle.
    bit e_wr   [MAXC];
    int e_addr [MAXC];
    int e_data [MAXC];
    bit e_done [MAXC];
    bit e_busy [MAXC];
    bit e_blk  [MAXC];
    bit e_sen  [MAXC];
    int e_stall[MAXC];
    int m_stall    = 0;
    int valid_from = -1;

    // observation counters for hand-computed expectations
    int sweep_wr_cnt = 0;
    int done_cnt     = 0;
    int last_done    = -1;
    int sen_low_cnt  = 0;

    always @(negedge clk) begin
        int  c;
        int  s;
        bit  idle;
        c = cyc;
        if (c < MAXC - NADDR - 4) begin
            if (valid_from >= 0 && c >= valid_from) begin
                chk("waitrequest", 32'(s_wait), 32'(e_blk[c]));
                chk("m_write", 32'(m_write), 32'(e_wr[c]));
                if (e_wr[c]) begin
                    chk("m_addr", 32'(m_addr), e_addr[c]);
                    chk("m_data", 32'(m_data), e_data[c]);
                end
                chk("done", 32'(done_o), 32'(e_done[c]));
                chk("busy", 32'(busy_o), 32'(e_busy[c]));
                chk("search_en", 32'(search_en_o), 32'(e_sen[c]));
                chk("stall_cnt", 32'(stall_cnt_o), e_stall[c]);
            end

            if (m_write && m_data == 8'hFF) sweep_wr_cnt++;
            if (done_o) begin
                done_cnt++;
                last_done = c;
            end
            if (!search_en_o) sen_low_cnt++;

            if (srst_i) begin
                for (int k = c + 1; k < MAXC; k++) begin
                    e_wr[k] = 0; e_done[k] = 0; e_busy[k] = 0;
                    e_blk[k] = 0; e_sen[k] = 0; e_stall[k] = 0;
                end
                m_stall = 0;
                if (valid_from < 0) valid_from = c + 1;
            end else if (valid_from >= 0) begin
                idle = !e_blk[c];
                if (idle && s_write) begin
                    e_wr[c+1]   = 1;
                    e_addr[c+1] = int'(s_addr);
                    e_data[c+1] = int'(s_data);
                end
                if (idle && run_stb_i) begin
                    s = c + 1 + (s_write ? 1 : 0);
                    for (int k = 0; k < NADDR; k++) begin
                        e_wr[s+k]   = 1;
                        e_addr[s+k] = k;
                        e_data[s+k] = 8'hFF;
                    end
                    e_done[s+NADDR] = 1;
                    for (int t = c + 1; t <= s + NADDR; t++) e_blk[t] = 1;
                    for (int t = c + 1; t < s + NADDR; t++) e_busy[t] = 1;
                    m_stall = 0;
                end else if (!idle && s_write && m_stall < 65535) begin
                    m_stall++;
                end
                e_sen[c+1] = en_i && !e_blk[c+1];
`ifdef HASH_LUT_ARBITER_STAT_EN
                e_stall[c+1] = m_stall;
`else
                e_stall[c+1] = 0;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        sweep_wr_cnt = 0;
        done_cnt     = 0;
        last_done    = -1;
        sen_low_cnt  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        srst_i = 1'b1; en_i = 1'b1; run_stb_i = 1'b0;
        s_write = 1'b0; s_addr = '0; s_data = '0;
        repeat (3) tick();
        srst_i = 1'b0;

        // reset state
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_mwrite", 32'(m_write), 32'd0);
        chk("rst_wait", 32'(s_wait), 32'd0);
        chk("rst_sen", 32'(search_en_o), 32'd0);
        chk("rst_stall", 32'(stall_cnt_o), 32'd0);
        repeat (2) tick();

        // idle host write forwarded one cycle later
        s_write = 1'b1; s_addr = 4'd5; s_data = 8'h3C;
        chk("idle_wait", 32'(s_wait), 32'd0);
        tick();
        s_write = 1'b0;
        chk("fwd_write", 32'(m_write), 32'd1);
        chk("fwd_addr", 32'(m_addr), 32'd5);
        chk("fwd_data", 32'(m_data), 32'h3C);
        tick();

        // search enable follows en_i while idle
        en_i = 1'b0;
        repeat (3) tick();
        en_i = 1'b1;
        repeat (2) tick();

        // plain sweep
        clear_mon();
        n = cyc;
        run_stb_i = 1'b1;
        tick();
        run_stb_i = 1'b0;
        repeat (20) tick();
        chk("sweep_writes", 32'(sweep_wr_cnt), 32'd16);
        chk("sweep_done_cnt", 32'(done_cnt), 32'd1);
        chk("sweep_done_cyc", 32'(last_done - n), 32'd17);
        chk("sweep_sen_low", 32'(sen_low_cnt), 32'd17);

        // host write stalled during a sweep
        n = cyc;
        run_stb_i = 1'b1;
        tick();
        run_stb_i = 1'b0;
        repeat (4) tick();
        s_write = 1'b1; s_addr = 4'd9; s_data = 8'h77;
        guard = 0;
        while (s_wait && guard < 40) begin
            tick();
            guard++;
        end
        chk("stall_accept_cyc", 32'(cyc - n), 32'd18);
        tick();
        s_write = 1'b0;
        chk("stall_fwd_write", 32'(m_write), 32'd1);
        chk("stall_fwd_addr", 32'(m_addr), 32'd9);
        chk("stall_fwd_data", 32'(m_data), 32'h77);
`ifdef HASH_LUT_ARBITER_STAT_EN
        chk("stall_cnt13", 32'(stall_cnt_o), 32'd13);
`endif
        repeat (3) tick();

        // run request together with a host write
        clear_mon();
        n = cyc;
        run_stb_i = 1'b1; s_write = 1'b1; s_addr = 4'd3; s_data = 8'h5A;
        tick();
        run_stb_i = 1'b0; s_write = 1'b0;
        chk("both_write", 32'(m_write), 32'd1);
        chk("both_addr", 32'(m_addr), 32'd3);
        chk("both_data", 32'(m_data), 32'h5A);
        repeat (20) tick();
        chk("both_sweep_writes", 32'(sweep_wr_cnt), 32'd16);
        chk("both_done_cyc", 32'(last_done - n), 32'd18);

        // reset in the middle of a sweep
        clear_mon();
        n = cyc;
        run_stb_i = 1'b1;
        tick();
        run_stb_i = 1'b0;
        repeat (7) tick();
        srst_i = 1'b1;
        tick();
        srst_i = 1'b0;
        chk("abort_mwrite", 32'(m_write), 32'd0);
        chk("abort_wait", 32'(s_wait), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        repeat (20) tick();
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_writes", 32'(sweep_wr_cnt), 32'd8);

        // repeated run requests during CLEAN and DONE are ignored
        clear_mon();
        n = cyc;
        run_stb_i = 1'b1;
        tick();
        run_stb_i = 1'b0;
        repeat (9) tick();
        run_stb_i = 1'b1;
        tick();
        run_stb_i = 1'b0;
        repeat (6) tick();
        run_stb_i = 1'b1;
        tick();
        run_stb_i = 1'b0;
        repeat (6) tick();
        chk("rerun_writes", 32'(sweep_wr_cnt), 32'd16);
        chk("rerun_done_cnt", 32'(done_cnt), 32'd1);
        chk("rerun_done_cyc", 32'(last_done - n), 32'd17);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_lut_arbiter.md
HASH_LUT_ARBITER -- requirements
Module: hash_lut_arbiter

Interface
REQ-001 The block SHALL have parameter AMM_LUT_ADDR_W, default 10, hash LUT address width in symbols.
REQ-002 The block SHALL have parameter AMM_LUT_DATA_W, default 8, hash LUT write data width.
REQ-003 The block SHALL have parameter CLEAN_DATA, default all ones (AMM_LUT_DATA_W bits), the value written to every address during a clean sweep.
REQ-004 The block SHALL have one clock, clk_i, and one reset, srst_i, which is synchronous and active-high.
REQ-005 Port list, one per line:
- clk_i  in  1  main clock
- srst_i  in  1  synchronous active-high reset
- en_i  in  1  search enable from CSR
- run_stb_i  in  1  single-cycle request to start a clean sweep
- busy_o  out  1  clean sweep in progress
- done_o  out  1  single-cycle pulse when a sweep completes
- search_en_o  out  1  gated search enable to the search engines
- amm_slave_address_i  in  AMM_LUT_ADDR_W  host write address
- amm_slave_write_i  in  1  host write request
- amm_slave_writedata_i  in  AMM_LUT_DATA_W  host write data
- amm_slave_waitrequest_o  out  1  host write stall
- amm_master_address_o  out  AMM_LUT_ADDR_W  LUT write address
- amm_master_write_o  out  1  LUT write strobe
- amm_master_writedata_o  out  AMM_LUT_DATA_W  LUT write data
- stall_cnt_o  out  16  count of host stall cycles

Function
REQ-006 The state machine SHALL have the states IDLE and CLEAN and a one-cycle DONE state.
REQ-007 Transitions SHALL be: IDLE->CLEAN on run_stb_i; CLEAN->DONE after the write to address 2^AMM_LUT_ADDR_W-1; DONE->IDLE unconditionally.
REQ-008 In IDLE, a host write SHALL be accepted with amm_slave_waitrequest_o=0 and SHALL appear on the master port exactly 1 cycle later, with address and data registered.
REQ-009 In CLEAN and DONE, amm_slave_waitrequest_o SHALL be 1, driven combinationally from state, and host writes SHALL NOT reach the master port.
REQ-010 Sweep: when run_stb_i is seen in cycle N, master writes of CLEAN_DATA SHALL occur at addresses 0,1,2,... in cycles N+1 through N+2^AMM_LUT_ADDR_W, one per cycle, with no gaps.
REQ-011 done_o SHALL pulse in cycle N+2^AMM_LUT_ADDR_W+1, and busy_o SHALL be 1 in cycles N+1 through N+2^AMM_LUT_ADDR_W.
REQ-012 search_en_o SHALL be registered and equal en_i & (next state == IDLE), so it drops in cycle N+1 and returns in the cycle after DONE.
REQ-013 If run_stb_i and a host write occur in the same IDLE cycle, the host write SHALL be accepted and forwarded in cycle N+1, and the sweep SHALL start in cycle N+2; all later sweep timing shifts by one cycle.
REQ-014 run_stb_i asserted in CLEAN or DONE SHALL be ignored; it SHALL NOT restart or extend the sweep.
REQ-015 The sweep address counter SHALL be AMM_LUT_ADDR_W+1 bits wide, so the terminal address is detected without wrapping.
REQ-016 amm_master_write_o SHALL be 0 in every cycle with no host write or sweep write.

Reset
REQ-017 srst_i SHALL force IDLE, clear the sweep counter, and drive all outputs to 0 on the next edge, except amm_slave_waitrequest_o, which follows state (0).
REQ-018 srst_i asserted mid-sweep SHALL abort the sweep without a done_o pulse; the LUT is left partially cleaned.

Configuration
REQ-019 Macro HASH_LUT_ARBITER_STAT_EN: when defined, stall_cnt_o SHALL count cycles with amm_slave_write_i=1 and amm_slave_waitrequest_o=1, saturating at 16'hFFFF and cleared by srst_i and by an accepted run_stb_i.
REQ-020 When HASH_LUT_ARBITER_STAT_EN is undefined, stall_cnt_o SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-021 ADDR_W=4, idle host write addr 5, data 8'h3C -> master write addr 5, data 8'h3C one cycle later; waitrequest stays 0.
REQ-022 ADDR_W=4, run_stb_i in cycle 10 -> 16 master writes of 8'hFF at addresses 0..15 in cycles 11-26; done_o in cycle 27; search_en_o low in cycles 11-27.
REQ-023 Host write held in cycle 15 of a sweep -> waitrequest=1 until cycle 28; write forwarded in cycle 29; with STAT_EN, stall_cnt_o=13.
REQ-024 run_stb_i together with host write addr 3 in cycle 10 -> addr 3 written in cycle 11; sweep writes in cycles 12-27.
REQ-025 srst_i in cycle 18 of a sweep -> master write=0 from cycle 19, no done_o, state IDLE, waitrequest 0.
REQ-026 Second run_stb_i in cycle 20 of a sweep -> exactly 16 sweep writes total; single done_o in cycle 27.
